// File: rtl/arbitro_pilha.sv
// rtl/arbitro_pilha.sv - UC/ULA arbiter and sequencer for the 8-bit, 16-deep operand stack
// Optional build macro ARB_UC_PRIO_EN: fixed UC priority instead of round-robin.
module arbitro_pilha #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uc_req,
    input  logic             uc_pop,
    input  logic [WIDTH-1:0] uc_din,
    output logic             uc_ack,
    output logic             uc_err,
    input  logic             ula_req,
    input  logic             ula_pop,
    input  logic [WIDTH-1:0] ula_din,
    output logic             ula_ack,
    output logic             ula_err,
    output logic [WIDTH-1:0] rd_data,
    output logic             stk_push,
    output logic             stk_pop,
    output logic             stk_sel,
    output logic [WIDTH-1:0] stk_din,
    input  logic [WIDTH-1:0] stk_dout,
    output logic [CW-1:0]    depth,
    output logic             full,
    output logic             empty
);

    typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

    state_t           state_q;
    logic             win_q, op_q;
    logic [WIDTH-1:0] data_q, rd_q, stk_din_q;
    logic [CW-1:0]    depth_q;
    logic             stk_push_q, stk_pop_q, stk_sel_q;
    logic             uc_ack_q, uc_err_q, ula_ack_q, ula_err_q;

    logic             win_d, op_d, rej_d;
    logic [WIDTH-1:0] data_d;

`ifndef ARB_UC_PRIO_EN
    logic             last_q;  // id of the requester served last
`endif

    assign full  = (depth_q == CW'(DEPTH));
    assign empty = (depth_q == '0);

    always_comb begin
`ifdef ARB_UC_PRIO_EN
        win_d = !uc_req;
`else
        win_d = (uc_req && ula_req) ? !last_q : !uc_req;
`endif
        op_d   = win_d ? ula_pop : uc_pop;
        data_d = win_d ? ula_din : uc_din;
        rej_d  = op_d ? empty : full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            win_q      <= 1'b0;
            op_q       <= 1'b0;
            data_q     <= '0;
            rd_q       <= '0;
            stk_din_q  <= '0;
            depth_q    <= '0;
            stk_push_q <= 1'b0;
            stk_pop_q  <= 1'b0;
            stk_sel_q  <= 1'b0;
            uc_ack_q   <= 1'b0;
            uc_err_q   <= 1'b0;
            ula_ack_q  <= 1'b0;
            ula_err_q  <= 1'b0;
`ifndef ARB_UC_PRIO_EN
            last_q     <= 1'b1;
`endif
        end else begin
            // strobes and acks are single-cycle pulses unless re-armed below
            stk_push_q <= 1'b0;
            stk_pop_q  <= 1'b0;
            uc_ack_q   <= 1'b0;
            uc_err_q   <= 1'b0;
            ula_ack_q  <= 1'b0;
            ula_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (uc_req || ula_req) begin
                        win_q  <= win_d;
                        op_q   <= op_d;
                        data_q <= data_d;
                        if (rej_d) begin
                            state_q   <= RESP;
                            uc_ack_q  <= !win_d;
                            uc_err_q  <= !win_d;
                            ula_ack_q <= win_d;
                            ula_err_q <= win_d;
                        end else begin
                            state_q    <= CMD;
                            stk_push_q <= !op_d;
                            stk_pop_q  <= op_d;
                            stk_sel_q  <= win_d;
                            stk_din_q  <= data_d;
                        end
                    end
                end
                CMD: begin
                    if (op_q) begin
                        depth_q <= depth_q - CW'(1);
                        state_q <= WAIT;
                    end else begin
                        depth_q   <= depth_q + CW'(1);
                        state_q   <= RESP;
                        uc_ack_q  <= !win_q;
                        ula_ack_q <= win_q;
                    end
                end
                WAIT: begin
                    rd_q      <= stk_dout;
                    state_q   <= RESP;
                    uc_ack_q  <= !win_q;
                    ula_ack_q <= win_q;
                end
                RESP: begin
`ifndef ARB_UC_PRIO_EN
                    last_q  <= win_q;
`endif
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign uc_ack   = uc_ack_q;
    assign uc_err   = uc_err_q;
    assign ula_ack  = ula_ack_q;
    assign ula_err  = ula_err_q;
    assign rd_data  = rd_q;
    assign stk_push = stk_push_q;
    assign stk_pop  = stk_pop_q;
    assign stk_sel  = stk_sel_q;
    assign stk_din  = stk_din_q;
    assign depth    = depth_q;

    // data_q is kept for debug visibility of the latched request
    logic unused_data;
    assign unused_data = ^data_q;

endmodule

// File: tb/tb_arbitro_pilha.sv
// tb/tb_arbitro_pilha.sv - table-driven scoreboard bench for arbitro_pilha with a behavioural stack
module tb_arbitro_pilha;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uc_req = 1'b0, uc_pop = 1'b0, ula_req = 1'b0, ula_pop = 1'b0;
    logic [7:0] uc_din = '0, ula_din = '0;
    logic       uc_ack, uc_err, ula_ack, ula_err;
    logic [7:0] rd_data, stk_din;
    logic [7:0] stk_dout = '0;
    logic       stk_push, stk_pop, stk_sel, full, empty;
    logic [4:0] depth;

    arbitro_pilha #(.WIDTH(8), .DEPTH(16), .CW(5)) dut (
        .clk(clk), .rst(rst),
        .uc_req(uc_req), .uc_pop(uc_pop), .uc_din(uc_din), .uc_ack(uc_ack), .uc_err(uc_err),
        .ula_req(ula_req), .ula_pop(ula_pop), .ula_din(ula_din), .ula_ack(ula_ack), .ula_err(ula_err),
        .rd_data(rd_data), .stk_push(stk_push), .stk_pop(stk_pop), .stk_sel(stk_sel),
        .stk_din(stk_din), .stk_dout(stk_dout), .depth(depth), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // behavioural stack with registered read data
    logic [7:0] mem [16];
    logic [4:0] sp = '0;
    always @(posedge clk) begin
        if (rst) sp <= '0;
        else if (stk_push) begin
            mem[sp[3:0]] <= stk_din;
            sp <= sp + 5'd1;
        end else if (stk_pop) begin
            stk_dout <= mem[sp[3:0] - 4'd1];
            sp <= sp - 5'd1;
        end
    end

    typedef struct {
        logic       uc_req, uc_pop;
        logic [7:0] uc_din;
        logic       ula_req, ula_pop;
        logic [7:0] ula_din;
        logic       win, err;
        logic [7:0] rd;
        logic [4:0] dep;
    } vec_t;

    typedef struct {
        logic       win, err;
        logic [7:0] rd;
        logic [4:0] dep;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[10];
    int   n_vec = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic ur, up, input logic [7:0] ud,
                                input logic lr, lp, input logic [7:0] ld,
                                input logic w, e, input logic [7:0] rd, input logic [4:0] dp);
        vec_t v;
        v.uc_req = ur; v.uc_pop = up; v.uc_din = ud;
        v.ula_req = lr; v.ula_pop = lp; v.ula_din = ld;
        v.win = w; v.err = e; v.rd = rd; v.dep = dp;
        return v;
    endfunction

    // scoreboard: every ack must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (stk_push || stk_pop) chk("strobe_excl", {31'd0, stk_push & stk_pop}, 32'd0);
        if (uc_ack || ula_ack) begin
            if (sb.size() == 0) chk("spurious_ack", {30'd0, uc_ack, ula_ack}, 32'd0);
            else begin
                e = sb.pop_front();
                chk("ack_err", {28'd0, uc_ack, uc_err, ula_ack, ula_err},
                    {28'd0, !e.win, !e.win & e.err, e.win, e.win & e.err});
                chk("rd_data", {24'd0, rd_data}, {24'd0, e.rd});
                chk("depth", {27'd0, depth}, {27'd0, e.dep});
                chk("full_empty", {30'd0, full, empty}, {30'd0, e.dep == 5'd16, e.dep == 5'd0});
            end
        end
    end

    task automatic reset_dut();
        rst = 1'b1; uc_req = 1'b0; ula_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_depth", {27'd0, depth}, 32'd0);
        chk("rst_flags", {30'd0, full, empty}, 32'd1);
        chk("rst_rd", {24'd0, rd_data}, 32'd0);
        chk("rst_outs", {25'd0, uc_ack, uc_err, ula_ack, ula_err, stk_push, stk_pop, stk_sel}, 32'd0);
        chk("rst_din", {24'd0, stk_din}, 32'd0);
    endtask

    task automatic do_txn(input vec_t v);
        exp_t       e;
        logic       w, op, got;
        logic [7:0] din;
        int         n, lat;
        w = v.win;
`ifdef ARB_UC_PRIO_EN
        if (v.uc_req && v.ula_req) w = 1'b0;
`endif
        op  = w ? v.ula_pop : v.uc_pop;
        din = w ? v.ula_din : v.uc_din;
        lat = v.err ? 1 : (op ? 3 : 2);
        e.win = w; e.err = v.err; e.rd = v.rd; e.dep = v.dep;
        sb.push_back(e);
        uc_req = v.uc_req; uc_pop = v.uc_pop; uc_din = v.uc_din;
        ula_req = v.ula_req; ula_pop = v.ula_pop; ula_din = v.ula_din;
        @(posedge clk);
        n = 0; got = 1'b0;
        while (!got && n < 6) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                if (v.err) chk("rej_nostrobe", {30'd0, stk_push, stk_pop}, 32'd0);
                else begin
                    chk("strobe", {29'd0, stk_push, stk_pop, stk_sel}, {29'd0, !op, op, w});
                    if (!op) chk("stk_din", {24'd0, stk_din}, {24'd0, din});
                end
            end
            got = uc_ack | ula_ack;
        end
        chk("latency", n, lat);
        @(posedge clk);
        #1 uc_req = 1'b0; ula_req = 1'b0;
    endtask

    initial begin
        tbl[0] = mk(1, 0, 8'h11, 1, 0, 8'h22, 0, 0, 8'h00, 1);
        tbl[1] = mk(0, 0, 8'h00, 1, 0, 8'h22, 1, 0, 8'h00, 2);
        tbl[2] = mk(1, 1, 8'h00, 0, 0, 8'h00, 0, 0, 8'h22, 1);
        tbl[3] = mk(0, 0, 8'h00, 1, 1, 8'h00, 1, 0, 8'h11, 0);
        tbl[4] = mk(0, 0, 8'h00, 1, 1, 8'h00, 1, 1, 8'h11, 0);
        tbl[5] = mk(1, 1, 8'h00, 1, 1, 8'h00, 0, 1, 8'h11, 0);
        tbl[6] = mk(1, 1, 8'h00, 1, 1, 8'h00, 1, 1, 8'h11, 0);
        tbl[7] = mk(1, 0, 8'h33, 1, 0, 8'h44, 0, 0, 8'h11, 1);
        tbl[8] = mk(0, 0, 8'h00, 1, 0, 8'h44, 1, 0, 8'h11, 2);
        tbl[9] = mk(0, 0, 8'h00, 1, 1, 8'h00, 1, 0, 8'h44, 1);

        reset_dut();
        do_txn(mk(1, 0, 8'h5A, 0, 0, 8'h00, 0, 0, 8'h00, 1));

        reset_dut();
        for (int i = 0; i < 10; i++) do_txn(tbl[i]);

        // fill to full, overflow rejection, then pop the top
        reset_dut();
        for (int k = 0; k <= 16; k++)
            do_txn(mk(1, 0, 8'(k), 0, 0, 8'h00, 0, k == 16, 8'h00, (k == 16) ? 5'd16 : 5'(k + 1)));
        do_txn(mk(1, 1, 8'h00, 0, 0, 8'h00, 0, 0, 8'h0F, 15));

        // reset in WAIT of a pop drops the transaction without an ack
        uc_req = 1'b1; uc_pop = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1; uc_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("wrst_depth", {27'd0, depth}, 32'd0);
        chk("wrst_rd", {24'd0, rd_data}, 32'd0);
        chk("wrst_outs", {25'd0, uc_ack, uc_err, ula_ack, ula_err, stk_push, stk_pop, stk_sel}, 32'd0);
        chk("wrst_flags", {30'd0, full, empty}, 32'd1);
        repeat (5) @(negedge clk);

        // both requesters pushing continuously
        reset_dut();
        for (int k = 0; k < 6; k++)
            do_txn(mk(1, 0, 8'(8'h60 + k), 1, 0, 8'(8'h70 + k), k[0], 0, 8'h00, 5'(k + 1)));

        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/arbitro_pilha.md
Name: arbitro_pilha

Overview:
Controller and arbiter for the 8-bit, 16-deep operand stack. Two requesters share the single stack port through this block: the control unit (UC) and the ALU (ULA). It sequences each push or pop into the stack's command strobes, tracks occupancy, blocks overflow and underflow, and returns popped data to the winning requester with an ack.

Parameters:
WIDTH, 8, data width of stack entries
DEPTH, 16, stack capacity in entries
CW, 5, occupancy counter width; must hold 0..DEPTH

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
uc_req  in  1  UC request; held stable until uc_ack
uc_pop  in  1  UC operation: 0=push, 1=pop
uc_din  in  WIDTH  UC push data
uc_ack  out  1  one-cycle completion pulse to UC
uc_err  out  1  valid with uc_ack; 1 = request rejected
ula_req  in  1  ULA request; held stable until ula_ack
ula_pop  in  1  ULA operation: 0=push, 1=pop
ula_din  in  WIDTH  ULA push data
ula_ack  out  1  one-cycle completion pulse to ULA
ula_err  out  1  valid with ula_ack; 1 = request rejected
rd_data  out  WIDTH  popped value; valid with the ack of a successful pop
stk_push  out  1  stack write strobe, one cycle
stk_pop  out  1  stack read strobe, one cycle
stk_sel  out  1  stack source select: 0=UC data, 1=ULA data
stk_din  out  WIDTH  data to the stack
stk_dout  in  WIDTH  stack registered read data; valid one cycle after stk_pop
depth  out  CW  current occupancy
full  out  1  depth==DEPTH
empty  out  1  depth==0

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, depth=0, rd_data=0, all acks, errs and strobes=0, stk_sel=0, stk_din=0, RR pointer set to favour UC. Any in-flight transaction is dropped with no ack. The same rst also clears the stack index.
- full and empty decode combinationally from the depth register.
- FSM states: IDLE, CMD, WAIT, RESP.
- IDLE:
  - Samples uc_req and ula_req. With none asserted, stay in IDLE.
  - Otherwise select the winner. With one requester, it wins. With both, the RR pointer decides: the requester not served last wins.
  - Latch winner id, op and data.
  - Push while full, or pop while empty: go to RESP with err=1. No stack strobe is issued and depth is unchanged.
  - Else go to CMD.
- CMD: assert stk_push or stk_pop for exactly one cycle, with stk_sel=winner and stk_din=latched data.
  - depth increments on push and decrements on pop, registered at the end of CMD.
  - Push goes to RESP. Pop goes to WAIT.
- WAIT: capture stk_dout into rd_data at the end of the cycle, then go to RESP.
- RESP:
  - Assert the winner's ack for exactly one cycle.
  - err equals the rejection flag.
  - rd_data holds its value until the next successful pop.
  - Update the RR pointer to the winner; rejected transactions count as served.
  - Go to IDLE.
- Latency, measured from the IDLE sampling edge (cycle 0):
  - push: strobe in cycle 1, ack in cycle 2
  - pop: strobe in cycle 1, ack in cycle 3
  - rejection: ack+err in cycle 1
- Handshake: a requester deasserts req in the cycle after ack, or keeps it high with a new op/data to issue back-to-back. Minimum spacing between a requester's transactions is one IDLE cycle.
- Only one transaction is in flight. The losing requester keeps req high and is served next.
- The losing requester's req, op and data are ignored until it is sampled in IDLE.
- stk_push and stk_pop are never high together. Outside CMD, both are 0.
- depth never exceeds DEPTH and never goes below 0.

Optional Feature:
ARB_UC_PRIO_EN:
- Defined: fixed priority. UC always wins simultaneous requests, and the RR pointer is not implemented.
- Undefined: round-robin as specified above.

Test Plan:
1. After reset, UC push 0x5A: cycle 1 has stk_push=1, stk_sel=0, stk_din=0x5A; cycle 2 has uc_ack=1, uc_err=0; depth=1, empty=0.
2. From empty, UC push 0x11 and ULA push 0x22 asserted together: UC is served first, then ULA, with stk_sel 0 then 1. Depth reaches 2. A following UC pop gives stk_pop in cycle 1 and uc_ack with rd_data=0x22 in cycle 3; depth=1.
3. ULA pop while empty: ula_ack=1, ula_err=1 in cycle 1. stk_pop is never asserted, depth stays 0, rd_data is unchanged.
4. 16 UC pushes of 0x00..0x0F give full=1. A 17th push gives uc_err=1 with no stk_push and depth=16. A following pop returns 0x0F.
5. rst pulsed during WAIT of a pop: no ack is issued. Next cycle: IDLE, depth=0, rd_data=0, all outputs 0.
6. Both requesters continuously push, 6 transactions:
   - without ARB_UC_PRIO_EN: grant order UC, ULA, UC, ULA, UC, ULA
   - with ARB_UC_PRIO_EN: all 6 go to UC, and ula_ack stays 0.
